// File: rtl/ram_access_controller.sv
// -----------------------------------------------------------------------------
// ram_access_controller
//
// Purpose
//   Shares one single-port 512x8 data RAM between an instruction-fetch
//   requester (If*) and a load/store requester (D*). A granted access is
//   sequenced as IDLE -> ISSUE -> WAIT -> GAP. MemMOV is high through ISSUE
//   and WAIT, and the controller waits for MemMOC in WAIT. GAP forces MemMOV
//   low for one cycle between accesses. Doubleword LDD/STD are split into two
//   word beats at A and A+4. Misaligned addresses, illegal opcodes and MOC
//   timeouts complete with a Done+Err pulse.
//
// Ports
//   Clk, Reset_n          clock, synchronous active-low reset
//   IfReq/IfAddr          fetch request (level) and word-aligned byte address
//   IfData/IfDone/IfErr   fetched word, one-cycle done pulse, error flag
//   DReq/DOP/DAddr        load/store request (level), opcode, byte address
//   DDataIn               store data ([63:32] is the first STD beat)
//   DDataOut/DDone/DErr   zero-extended load data, done pulse, error flag
//   MemMOV..MemOP         RAM strobe, direction (1=load), address, data, op
//   MemDataOut/MemMOC     RAM read data and completion
// -----------------------------------------------------------------------------
module ram_access_controller #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [31:0]       IfData,
  output logic              IfDone,
  output logic              IfErr,
  input  logic              DReq,
  input  logic [5:0]        DOP,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [63:0]       DDataIn,
  output logic [63:0]       DDataOut,
  output logic              DDone,
  output logic              DErr,
  output logic              MemMOV,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemDataIn,
  output logic [5:0]        MemOP,
  input  logic [31:0]       MemDataOut,
  input  logic              MemMOC
);

  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STD  = 6'b000111;

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_e;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_e;

  // Sequencer state
  state_e             state_q;
  port_e              last_gnt_q;
  port_e              port_q;
  logic [5:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               load_q;
  logic               double_q;
  logic               beat_q;
  logic               more_q;
  logic [31:0]        wdata_lo_q;
  logic [31:0]        rdata_hi_q;
  logic [TMR_W-1:0]   timer_q;

  // Registered outputs
  logic [31:0]        if_data_q;
  logic               if_done_q;
  logic               if_err_q;
  logic [63:0]        d_data_q;
  logic               d_done_q;
  logic               d_err_q;
  logic               mem_mov_q;
  logic               mem_rw_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_din_q;
  logic [5:0]         mem_op_q;

  // Opcode decode for the D port
  logic d_legal;
  logic d_aligned;
  logic d_load;
  logic d_double;

  always_comb begin
    // NOTE: every combinational output is given a default before the case so
    // that no path leaves it unassigned; an unassigned path would infer a latch.
    d_legal   = 1'b1;
    d_aligned = 1'b1;
    d_load    = 1'b1;
    d_double  = 1'b0;
    case (DOP)
      OP_LD:   d_aligned = (DAddr[1:0] == 2'b00);
      OP_LDUH: d_aligned = ~DAddr[0];
      OP_LDUB: d_aligned = 1'b1;
      OP_LDD: begin
        d_aligned = (DAddr[2:0] == 3'b000);
        d_double  = 1'b1;
      end
      OP_ST: begin
        d_aligned = (DAddr[1:0] == 2'b00);
        d_load    = 1'b0;
      end
      OP_STH: begin
        d_aligned = ~DAddr[0];
        d_load    = 1'b0;
      end
      OP_STB: d_load = 1'b0;
      OP_STD: begin
        d_aligned = (DAddr[2:0] == 3'b000);
        d_load    = 1'b0;
        d_double  = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  // Round-robin grant. A port whose Done is currently showing is not eligible,
  // so a requester that has not yet dropped its level request is never
  // re-served and Done cannot stretch past one cycle.
  logic if_elig;
  logic d_elig;
  logic gnt_if;
  logic gnt_d;

  always_comb begin
    if_elig = IfReq & ~if_done_q;
    d_elig  = DReq & ~d_done_q;
    gnt_d   = d_elig & (~if_elig | (last_gnt_q == PORT_IF));
    gnt_if  = if_elig & ~gnt_d;
  end

  // Final load data for the D port, shaped by the latched opcode.
  logic [63:0] d_load_data;

  always_comb begin
    d_load_data = {32'b0, MemDataOut};
    if (double_q) begin
      d_load_data = {rdata_hi_q, MemDataOut};
    end else if (op_q == OP_LDUH) begin
      d_load_data = {48'b0, MemDataOut[15:0]};
    end else if (op_q == OP_LDUB) begin
      d_load_data = {56'b0, MemDataOut[7:0]};
    end
  end

  logic wait_timeout;
  assign wait_timeout = (timer_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      last_gnt_q <= PORT_IF;
      port_q     <= PORT_IF;
      op_q       <= '0;
      addr_q     <= '0;
      load_q     <= 1'b0;
      double_q   <= 1'b0;
      beat_q     <= 1'b0;
      more_q     <= 1'b0;
      wdata_lo_q <= '0;
      rdata_hi_q <= '0;
      timer_q    <= '0;
      if_data_q  <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_data_q   <= '0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
      mem_mov_q  <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_op_q   <= '0;
    end else begin
      // Done/Err are pulses: cleared every cycle unless set below.
      if_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (gnt_if) begin
            last_gnt_q <= PORT_IF;
            if (IfAddr[1:0] != 2'b00) begin
              if_done_q <= 1'b1;
              if_err_q  <= 1'b1;
            end else begin
              port_q     <= PORT_IF;
              op_q       <= OP_LD;
              addr_q     <= IfAddr;
              load_q     <= 1'b1;
              double_q   <= 1'b0;
              beat_q     <= 1'b0;
              more_q     <= 1'b0;
              mem_mov_q  <= 1'b1;
              mem_rw_q   <= 1'b1;
              mem_addr_q <= IfAddr;
              mem_op_q   <= OP_LD;
              mem_din_q  <= '0;
              state_q    <= S_ISSUE;
            end
          end else if (gnt_d) begin
            last_gnt_q <= PORT_D;
            if (!d_legal || !d_aligned) begin
              d_done_q <= 1'b1;
              d_err_q  <= 1'b1;
            end else begin
              port_q     <= PORT_D;
              op_q       <= DOP;
              addr_q     <= DAddr;
              load_q     <= d_load;
              double_q   <= d_double;
              beat_q     <= 1'b0;
              more_q     <= 1'b0;
              wdata_lo_q <= DDataIn[31:0];
              mem_mov_q  <= 1'b1;
              mem_rw_q   <= d_load;
              mem_addr_q <= DAddr;
              // Doubleword beats are issued to the RAM as plain word ops.
              if (d_double) begin
                mem_op_q <= d_load ? OP_LD : OP_ST;
              end else begin
                mem_op_q <= DOP;
              end
              if (d_load) begin
                mem_din_q <= '0;
              end else if (d_double) begin
                mem_din_q <= DDataIn[63:32];
              end else begin
                mem_din_q <= DDataIn[31:0];
              end
              state_q <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (MemMOC && double_q && !beat_q) begin
            // First beat of a doubleword: keep its data, no Done yet.
            rdata_hi_q <= MemDataOut;
            more_q     <= 1'b1;
            mem_mov_q  <= 1'b0;
            state_q    <= S_GAP;
          end else if (MemMOC || wait_timeout) begin
            // Completion or abort; an abort drops any remaining beat.
            mem_mov_q <= 1'b0;
            state_q   <= S_GAP;
            if (port_q == PORT_IF) begin
              if_done_q <= 1'b1;
              if_err_q  <= ~MemMOC;
              if (MemMOC) begin
                if_data_q <= MemDataOut;
              end
            end else begin
              d_done_q <= 1'b1;
              d_err_q  <= ~MemMOC;
              if (MemMOC && load_q) begin
                d_data_q <= d_load_data;
              end
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        S_GAP: begin
          if (more_q) begin
            more_q     <= 1'b0;
            beat_q     <= 1'b1;
            mem_mov_q  <= 1'b1;
            mem_addr_q <= addr_q + ADDR_W'(4);
            if (!load_q) begin
              mem_din_q <= wdata_lo_q;
            end
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IfData       = if_data_q;
  assign IfDone       = if_done_q;
  assign IfErr        = if_err_q;
  assign DDataOut     = d_data_q;
  assign DDone        = d_done_q;
  assign DErr         = d_err_q;
  assign MemMOV       = mem_mov_q;
  assign MemReadWrite = mem_rw_q;
  assign MemAddress   = mem_addr_q;
  assign MemDataIn    = mem_din_q;
  assign MemOP        = mem_op_q;

endmodule

// File: tb/tb_ram_access_controller.sv
// -----------------------------------------------------------------------------
// tb_ram_access_controller
//
// Self-checking bench for ram_access_controller. A behavioural big-endian
// 512x8 RAM answers MemMOV with MemMOC after a programmable delay and logs
// every MOV rising edge. Expected completions are queued when a request is
// driven and popped when the matching Done appears.
// -----------------------------------------------------------------------------
module tb_ram_access_controller;

  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STD  = 6'b000111;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        IfReq = 1'b0;
  logic [8:0]  IfAddr = '0;
  logic [31:0] IfData;
  logic        IfDone;
  logic        IfErr;
  logic        DReq = 1'b0;
  logic [5:0]  DOP = '0;
  logic [8:0]  DAddr = '0;
  logic [63:0] DDataIn = '0;
  logic [63:0] DDataOut;
  logic        DDone;
  logic        DErr;
  logic        MemMOV;
  logic        MemReadWrite;
  logic [8:0]  MemAddress;
  logic [31:0] MemDataIn;
  logic [5:0]  MemOP;
  logic [31:0] MemDataOut;
  logic        MemMOC;

  ram_access_controller #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfData(IfData), .IfDone(IfDone), .IfErr(IfErr),
    .DReq(DReq), .DOP(DOP), .DAddr(DAddr), .DDataIn(DDataIn),
    .DDataOut(DDataOut), .DDone(DDone), .DErr(DErr),
    .MemMOV(MemMOV), .MemReadWrite(MemReadWrite), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .MemOP(MemOP), .MemDataOut(MemDataOut), .MemMOC(MemMOC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [8:0]  addr;
    logic [5:0]  op;
    logic        rw;
    logic [31:0] din;
  } mov_t;

  exp_t exp_q[$];
  mov_t mov_log[$];

  int n_vec = 0;
  int n_err = 0;

  // RAM model state
  logic [7:0] mem [512];
  int  ram_lat = 0;
  bit  moc_en = 1'b1;
  bit  served;
  int  lat_cnt;
  logic mov_prev, d_done_prev, if_done_prev;
  int  pulse_err = 0;

  // Behavioural RAM plus monitors, evaluated 1 time unit after each edge.
  initial begin
    int a;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    MemMOC = 1'b0;
    MemDataOut = '0;
    served = 1'b0;
    lat_cnt = 0;
    mov_prev = 1'b0;
    d_done_prev = 1'b0;
    if_done_prev = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      if (MemMOV && !mov_prev) mov_log.push_back('{MemAddress, MemOP, MemReadWrite, MemDataIn});
      mov_prev = MemMOV;
      if (DDone && d_done_prev) pulse_err++;
      if (IfDone && if_done_prev) pulse_err++;
      d_done_prev = DDone;
      if_done_prev = IfDone;
      if (!MemMOV) begin
        MemMOC = 1'b0;
        served = 1'b0;
        lat_cnt = 0;
      end else if (!served && moc_en) begin
        if (lat_cnt >= ram_lat) begin
          a = int'(MemAddress);
          case (MemOP)
            OP_LD:   MemDataOut = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
            OP_LDUH: MemDataOut = {16'h0, mem[a], mem[a+1]};
            OP_LDUB: MemDataOut = {24'h0, mem[a]};
            OP_ST: begin
              mem[a]   = MemDataIn[31:24];
              mem[a+1] = MemDataIn[23:16];
              mem[a+2] = MemDataIn[15:8];
              mem[a+3] = MemDataIn[7:0];
            end
            OP_STH: begin
              mem[a]   = MemDataIn[15:8];
              mem[a+1] = MemDataIn[7:0];
            end
            OP_STB: mem[a] = MemDataIn[7:0];
            default: MemDataOut = 32'hDEAD_BEEF;
          endcase
          MemMOC = 1'b1;
          served = 1'b1;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  task automatic apply_reset();
    Reset_n = 1'b0;
    IfReq = 1'b0;
    DReq = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Drives one D request after an idle cycle; waits (bounded) for DDone.
  task automatic run_d(input logic [5:0] op, input logic [8:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output logic dn, output int cyc);
    @(posedge Clk);
    #1;
    DOP = op;
    DAddr = a;
    DDataIn = wd;
    DReq = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (!DDone && cyc < 100);
    rd = DDataOut;
    er = DErr;
    dn = DDone;
    DReq = 1'b0;
  endtask

  task automatic run_if(input logic [8:0] a, output logic [31:0] rd, output logic er,
                        output logic dn, output int cyc);
    @(posedge Clk);
    #1;
    IfAddr = a;
    IfReq = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (!IfDone && cyc < 100);
    rd = IfData;
    er = IfErr;
    dn = IfDone;
    IfReq = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({MemMOV, MemReadWrite, MemAddress, MemDataIn, MemOP} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got mov=%b rw=%b addr=%h din=%h op=%b want all 0",
               MemMOV, MemReadWrite, MemAddress, MemDataIn, MemOP);
    end
    n_vec++;
    if ({DDone, DErr, DDataOut} !== '0) begin
      n_err++;
      $display("FAIL reset_d: got done=%b err=%b data=%h want 0", DDone, DErr, DDataOut);
    end
    n_vec++;
    if ({IfDone, IfErr, IfData} !== '0) begin
      n_err++;
      $display("FAIL reset_if: got done=%b err=%b data=%h want 0", IfDone, IfErr, IfData);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_word();
    logic [63:0] rd;
    logic [31:0] ird;
    logic er, dn;
    int cyc, base;
    exp_t e;

    base = mov_log.size();
    exp_q.push_back('{1'b1, 64'h0, 1'b0});
    run_d(OP_ST, 9'd0, 64'h0000_0000_AE91_0F2B, rd, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, cyc} !== {1'b1, e.err, 32'd3}) begin
      n_err++;
      $display("FAIL st_word: got done=%b err=%b cyc=%0d want done=1 err=%b cyc=3", dn, er, cyc, e.err);
    end
    n_vec++;
    if (mov_log.size() != base + 1) begin
      n_err++;
      $display("FAIL st_word_mov: got %0d MOV pulses want 1", mov_log.size() - base);
    end else if ({mov_log[base].op, mov_log[base].rw, mov_log[base].din} !== {OP_ST, 1'b0, 32'hAE91_0F2B}) begin
      n_err++;
      $display("FAIL st_word_mov: got op=%b rw=%b din=%h want op=000100 rw=0 din=ae910f2b",
               mov_log[base].op, mov_log[base].rw, mov_log[base].din);
    end

    base = mov_log.size();
    exp_q.push_back('{1'b1, 64'h0000_0000_AE91_0F2B, 1'b0});
    run_d(OP_LD, 9'd0, 64'h0, rd, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, rd} !== {1'b1, e.err, e.data}) begin
      n_err++;
      $display("FAIL ld_word: got done=%b err=%b data=%h want done=1 err=%b data=%h", dn, er, rd, e.err, e.data);
    end
    n_vec++;
    if (cyc !== 3) begin
      n_err++;
      $display("FAIL ld_latency: got %0d cycles want 3", cyc);
    end
    n_vec++;
    if (mov_log.size() != base + 1) begin
      n_err++;
      $display("FAIL ld_word_mov: got %0d MOV pulses want 1", mov_log.size() - base);
    end else if ({mov_log[base].op, mov_log[base].rw, mov_log[base].addr} !== {OP_LD, 1'b1, 9'd0}) begin
      n_err++;
      $display("FAIL ld_word_mov: got op=%b rw=%b addr=%0d want op=001000 rw=1 addr=0",
               mov_log[base].op, mov_log[base].rw, mov_log[base].addr);
    end

    exp_q.push_back('{1'b0, 64'h0000_0000_AE91_0F2B, 1'b0});
    run_if(9'd0, ird, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, ird, cyc} !== {1'b1, e.err, e.data[31:0], 32'd3}) begin
      n_err++;
      $display("FAIL if_fetch: got done=%b err=%b data=%h cyc=%0d want done=1 err=0 data=%h cyc=3",
               dn, er, ird, cyc, e.data[31:0]);
    end
  endtask

  task automatic test_half_byte();
    logic [5:0]  ops [4] = '{OP_STH, OP_LDUH, OP_STB, OP_LDUB};
    logic [8:0]  adr [4] = '{9'd4, 9'd4, 9'd6, 9'd6};
    logic [63:0] wdv [4] = '{64'h0000_0000_FFFF_AABB, 64'h0, 64'h0000_0000_FFFF_FF55, 64'h0};
    logic [63:0] exd [4] = '{64'h0, 64'h0000_0000_0000_AABB, 64'h0, 64'h0000_0000_0000_0055};
    logic [63:0] rd;
    logic er, dn;
    int cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{1'b1, exd[i], 1'b0});
      run_d(ops[i], adr[i], wdv[i], rd, er, dn, cyc);
      e = exp_q.pop_front();
      n_vec++;
      if ({dn, er} !== {1'b1, e.err} || (i % 2 == 1 && rd !== e.data)) begin
        n_err++;
        $display("FAIL half_byte[%0d]: got done=%b err=%b data=%h want done=1 err=0 data=%h",
                 i, dn, er, rd, e.data);
      end
    end
  endtask

  task automatic test_double();
    logic [63:0] rd;
    logic er, dn;
    int cyc, base;
    exp_t e;

    base = mov_log.size();
    exp_q.push_back('{1'b1, 64'h0, 1'b0});
    run_d(OP_STD, 9'd8, 64'h1122_3344_5566_7788, rd, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, cyc} !== {1'b1, e.err, 32'd6}) begin
      n_err++;
      $display("FAIL std: got done=%b err=%b cyc=%0d want done=1 err=0 cyc=6", dn, er, cyc);
    end
    n_vec++;
    if (mov_log.size() != base + 2) begin
      n_err++;
      $display("FAIL std_beats: got %0d MOV pulses want 2", mov_log.size() - base);
    end else if ({mov_log[base].addr, mov_log[base].op, mov_log[base].din,
                  mov_log[base+1].addr, mov_log[base+1].op, mov_log[base+1].din} !==
                 {9'd8, OP_ST, 32'h1122_3344, 9'd12, OP_ST, 32'h5566_7788}) begin
      n_err++;
      $display("FAIL std_beats: got %0d/%b/%h %0d/%b/%h want 8/000100/11223344 12/000100/55667788",
               mov_log[base].addr, mov_log[base].op, mov_log[base].din,
               mov_log[base+1].addr, mov_log[base+1].op, mov_log[base+1].din);
    end

    base = mov_log.size();
    exp_q.push_back('{1'b1, 64'h1122_3344_5566_7788, 1'b0});
    run_d(OP_LDD, 9'd8, 64'h0, rd, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, rd} !== {1'b1, e.err, e.data}) begin
      n_err++;
      $display("FAIL ldd: got done=%b err=%b data=%h want done=1 err=0 data=%h", dn, er, rd, e.data);
    end
    n_vec++;
    if (mov_log.size() != base + 2) begin
      n_err++;
      $display("FAIL ldd_beats: got %0d MOV pulses want 2", mov_log.size() - base);
    end else if ({mov_log[base].addr, mov_log[base].op, mov_log[base+1].addr, mov_log[base+1].op} !==
                 {9'd8, OP_LD, 9'd12, OP_LD}) begin
      n_err++;
      $display("FAIL ldd_beats: got %0d/%b %0d/%b want 8/001000 12/001000",
               mov_log[base].addr, mov_log[base].op, mov_log[base+1].addr, mov_log[base+1].op);
    end
  endtask

  task automatic test_reject();
    logic [5:0] ops [5] = '{OP_LD, OP_STH, 6'b111111, OP_LDD, OP_STD};
    logic [8:0] adr [5] = '{9'd2, 9'd5, 9'd0, 9'd4, 9'd12};
    logic [63:0] rd;
    logic [31:0] ird;
    logic er, dn;
    int cyc, base;
    exp_t e;
    base = mov_log.size();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{1'b1, 64'h0, 1'b1});
      run_d(ops[i], adr[i], 64'hFFFF_FFFF_FFFF_FFFF, rd, er, dn, cyc);
      e = exp_q.pop_front();
      n_vec++;
      if ({dn, er, cyc} !== {1'b1, e.err, 32'd1}) begin
        n_err++;
        $display("FAIL reject[%0d]: got done=%b err=%b cyc=%0d want done=1 err=1 cyc=1", i, dn, er, cyc);
      end
    end
    exp_q.push_back('{1'b0, 64'h0, 1'b1});
    run_if(9'd1, ird, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, cyc} !== {1'b1, e.err, 32'd1}) begin
      n_err++;
      $display("FAIL reject_if: got done=%b err=%b cyc=%0d want done=1 err=1 cyc=1", dn, er, cyc);
    end
    n_vec++;
    if (mov_log.size() != base) begin
      n_err++;
      $display("FAIL reject_mov: got %0d MOV pulses want 0", mov_log.size() - base);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] rd;
    logic er, dn;
    int cyc;
    exp_t e;
    moc_en = 1'b0;
    // Aborted load must leave the previous (LDD) result in place.
    exp_q.push_back('{1'b1, 64'h1122_3344_5566_7788, 1'b1});
    run_d(OP_LD, 9'd0, 64'h0, rd, er, dn, cyc);
    e = exp_q.pop_front();
    n_vec++;
    if ({dn, er, MemMOV, cyc} !== {1'b1, e.err, 1'b0, 32'd17}) begin
      n_err++;
      $display("FAIL timeout: got done=%b err=%b mov=%b cyc=%0d want done=1 err=1 mov=0 cyc=17",
               dn, er, MemMOV, cyc);
    end
    n_vec++;
    if (rd !== e.data) begin
      n_err++;
      $display("FAIL timeout_hold: got data=%h want %h", rd, e.data);
    end
    moc_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    moc_en = 1'b0;
    @(posedge Clk);
    #1;
    DOP = OP_LD;
    DAddr = 9'd0;
    DReq = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    n_vec++;
    if (MemMOV !== 1'b1) begin
      n_err++;
      $display("FAIL mid_wait_mov: got mov=%b want 1", MemMOV);
    end
    Reset_n = 1'b0;
    DReq = 1'b0;
    @(posedge Clk);
    #1;
    n_vec++;
    if ({MemMOV, MemAddress, MemOP, MemReadWrite, DDone, DErr, DDataOut, IfData, IfDone} !== '0) begin
      n_err++;
      $display("FAIL mid_wait_reset: got mov=%b addr=%h op=%b ddone=%b ddata=%h ifdata=%h want all 0",
               MemMOV, MemAddress, MemOP, DDone, DDataOut, IfData);
    end
    Reset_n = 1'b1;
    moc_en = 1'b1;
  endtask

  task automatic test_arbitration();
    exp_t e;
    int cyc, done_cnt;
    logic re_d, re_if;
    apply_reset();
    Reset_n = 1'b1;
    ram_lat = 1;
    IfAddr = 9'd0;
    DOP = OP_LD;
    DAddr = 9'd4;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b1, 64'h0000_0000_AABB_5500, 1'b0});
      exp_q.push_back('{1'b0, 64'h0000_0000_AE91_0F2B, 1'b0});
    end
    IfReq = 1'b1;
    DReq = 1'b1;
    done_cnt = 0;
    cyc = 0;
    re_d = 1'b0;
    re_if = 1'b0;
    while (done_cnt < 4 && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
      if (re_d) begin DReq = 1'b1; re_d = 1'b0; end
      if (re_if) begin IfReq = 1'b1; re_if = 1'b0; end
      if (DDone || IfDone) begin
        e = exp_q.pop_front();
        done_cnt++;
        n_vec++;
        if (DDone !== e.is_d || (DDone && IfDone)) begin
          n_err++;
          $display("FAIL arb_order[%0d]: got ddone=%b ifdone=%b want d=%b", done_cnt, DDone, IfDone, e.is_d);
        end
        n_vec++;
        if (e.is_d ? ({DErr, DDataOut} !== {1'b0, e.data}) : ({IfErr, IfData} !== {1'b0, e.data[31:0]})) begin
          n_err++;
          $display("FAIL arb_data[%0d]: got d=%h if=%h want %h", done_cnt, DDataOut, IfData, e.data);
        end
        if (DDone) begin DReq = 1'b0; re_d = 1'b1; end
        if (IfDone) begin IfReq = 1'b0; re_if = 1'b1; end
      end
    end
    IfReq = 1'b0;
    DReq = 1'b0;
    ram_lat = 0;
    n_vec++;
    if (done_cnt !== 4) begin
      n_err++;
      $display("FAIL arb_count: got %0d completions want 4", done_cnt);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_word();
    test_half_byte();
    test_double();
    test_reject();
    test_timeout();
    test_reset_mid_wait();
    test_arbitration();
    repeat (3) @(posedge Clk);
    #1;
    n_vec++;
    if (pulse_err !== 0) begin
      n_err++;
      $display("FAIL done_width: got %0d multi-cycle Done pulses want 0", pulse_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
